// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader for instruction memory. It receives a byte
//               stream, packs it big-endian into 32-bit words and writes them
//               to program memory starting at BASE_ADDR. It then checks a
//               trailing XOR checksum and reports done or error.
//
//               Stream : LEN[31:0] | WORD_0 .. WORD_N-1 | CSUM[31:0]
//                        every field is sent MSB byte first
//
// Ports       : clock        - system clock, rising edge
//               reset        - asynchronous, active-low reset
//               start        - pulse that begins a load (ignored while busy)
//               in_data      - incoming byte
//               in_valid     - in_data is valid this cycle
//               in_ready     - loader accepts a byte this cycle
//               mem_we       - one-cycle memory write strobe
//               mem_addr     - word write address
//               mem_data     - instruction word to write
//               busy         - load in progress
//               done         - sticky: load finished with a good checksum
//               error        - sticky: bad length or bad checksum
//               words_loaded - words written in the current/last load
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module program_loader #(
  parameter int unsigned           ADDR_WIDTH = 26,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_WORDS  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_len  = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;
  localparam logic [1:0] c_st_sum  = 2'd3;

  logic [1:0]            state_q,        state_d;
  logic [1:0]            byte_cnt_q,     byte_cnt_d;
  logic [23:0]           shift_q,        shift_d;
  logic [31:0]           words_left_q,   words_left_d;
  logic [31:0]           checksum_q,     checksum_d;
  logic [ADDR_WIDTH-1:0] words_loaded_q, words_loaded_d;
  logic                  mem_we_q,       mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,     mem_addr_d;
  logic [31:0]           mem_data_q,     mem_data_d;
  logic                  done_q,         done_d;
  logic                  error_q,        error_d;

  logic                  w_xfer;
  logic                  w_last_byte;
  logic [31:0]           w_word;

  // Only three bytes are kept. The fourth byte is taken straight from in_data,
  // so the completed field is ready in the same cycle as its last transfer.
  assign w_xfer      = in_valid & in_ready;
  assign w_last_byte = w_xfer & (byte_cnt_q == 2'd3);
  assign w_word      = {shift_q, in_data};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d = c_st_len;
        end
      end
      c_st_len: begin
        if (w_last_byte) begin
          if (w_word == 32'd0) begin
            state_d = c_st_sum;
          end else if (w_word > MAX_WORDS) begin
            state_d = c_st_idle;
          end else begin
            state_d = c_st_data;
          end
        end
      end
      c_st_data: begin
        if (w_last_byte && (words_left_q == 32'd1)) begin
          state_d = c_st_sum;
        end
      end
      c_st_sum: begin
        if (w_last_byte) begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state_q != c_st_idle) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    words_left_d   = words_left_q;
    checksum_d     = checksum_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    done_d         = done_q;
    error_d        = error_q;

    if ((state_q == c_st_idle) && start) begin
      done_d         = 1'b0;
      error_d        = 1'b0;
      words_loaded_d = '0;
      checksum_d     = '0;
      byte_cnt_d     = 2'd0;
    end

    // Every field is exactly four bytes long, so a free-running 2-bit
    // counter marks field boundaries in all receiving states.
    if (w_xfer) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], in_data};
    end

    if (w_last_byte) begin
      case (state_q)
        c_st_len: begin
          words_left_d = w_word;
          if (w_word > MAX_WORDS) begin
            error_d = 1'b1;
          end
        end
        c_st_data: begin
          mem_we_d       = 1'b1;
          mem_addr_d     = BASE_ADDR + words_loaded_q;
          mem_data_d     = w_word;
          words_loaded_d = words_loaded_q + ADDR_WIDTH'(1);
          checksum_d     = checksum_q ^ w_word;
          words_left_d   = words_left_q - 32'd1;
        end
        c_st_sum: begin
          if (w_word == checksum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt_q     <= 2'd0;
      shift_q        <= '0;
      words_left_q   <= '0;
      checksum_q     <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      words_left_q   <= words_left_d;
      checksum_q     <= checksum_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. It uses directed
//               and random loads, and compares them against expectations
//               computed from the stream format.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  localparam int unsigned    AW   = 26;
  localparam int unsigned    MAXW = 1024;
  localparam logic [AW-1:0]  BASE = '0;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          start    = 1'b0;
  logic [7:0]    in_data  = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] words_loaded;

  program_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (MAXW)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            stalls  = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic [31:0]   tx_words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every write strobe the memory would see
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
    int guard;
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    start    = with_start;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      stalls++;
      guard++;
      @(negedge clock);
    end
    if (guard >= 50) check("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic start_on_last);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], gap, (k == 0) ? start_on_last : 1'b0);
    end
  endtask

  // Full load of tx_words with the given length and checksum fields
  task automatic run_load(input logic [31:0] len, input logic [31:0] cs, input int gap,
                          input logic start_on_last);
    logic [31:0] exp_cs;
    wr_addr_q.delete();
    wr_data_q.delete();
    stalls = 0;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    send_word(len, gap, 1'b0);
    if (len > MAXW) begin
      in_valid = 1'b0;
      check("len_err_error", {63'd0, error}, 64'd1);
      check("len_err_busy", {63'd0, busy}, 64'd0);
      check("len_err_ready", {63'd0, in_ready}, 64'd0);
      check("len_err_done", {63'd0, done}, 64'd0);
      check("len_err_words", 64'(words_loaded), 64'd0);
      repeat (2) @(negedge clock);
      check("len_err_writes", 64'(wr_data_q.size()), 64'd0);
      return;
    end
    exp_cs = 32'd0;
    for (int i = 0; i < int'(len); i++) begin
      send_word(tx_words[i], gap, 1'b0);
      check("wr_strobe", {63'd0, mem_we}, 64'd1);
      check("wr_addr", 64'(mem_addr), 64'(BASE + AW'(i)));
      check("wr_data", 64'(mem_data), 64'(tx_words[i]));
      exp_cs ^= tx_words[i];
    end
    send_word(cs, gap, start_on_last);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_ready", {63'd0, in_ready}, 64'd0);
    check("end_done", {63'd0, done}, {63'd0, cs == exp_cs});
    check("end_error", {63'd0, error}, {63'd0, cs != exp_cs});
    check("end_words", 64'(words_loaded), 64'(len));
    check("end_nwrites", 64'(wr_data_q.size()), 64'(len));
    for (int i = 0; i < wr_data_q.size() && i < int'(len); i++) begin
      check("log_addr", 64'(wr_addr_q[i]), 64'(BASE + AW'(i)));
      check("log_data", 64'(wr_data_q[i]), 64'(tx_words[i]));
    end
    check("stalls", 64'(stalls), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {in_ready, mem_we, busy, done, error}, 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_data"}, 64'(mem_data), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] len;
    logic [31:0] cs;
    int          n;

    repeat (3) @(negedge clock);
    check_all_zero("reset_state");
    reset = 1'b1;
    @(negedge clock);

    // Two-word load, back to back; start with the final byte is ignored
    tx_words = '{32'h01234567, 32'h89ABCDEF};
    run_load(32'd2, 32'h88888888, 0, 1'b1);

    // Same stream with three idle cycles before every byte
    run_load(32'd2, 32'h88888888, 3, 1'b0);

    // Empty program
    tx_words.delete();
    run_load(32'd0, 32'd0, 0, 1'b0);

    // One past the length limit
    run_load(32'h00000401, 32'd0, 0, 1'b0);

    // Bad checksum: word remains written, error flagged
    tx_words = '{32'hDEADBEEF};
    run_load(32'd1, 32'hDEADBEEE, 1, 1'b0);

    // Reset in the middle of the first data word
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_word(32'd1, 0, 1'b0);
    send_byte(8'hDE, 0, 1'b0);
    send_byte(8'hAD, 0, 1'b0);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_reset_writes", 64'(wr_data_q.size()), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    tx_words = '{32'hCAFEF00D, 32'h12345678, 32'h0BADC0DE};
    run_load(32'd3, 32'hCAFEF00D ^ 32'h12345678 ^ 32'h0BADC0DE, 0, 1'b0);

    // Largest legal program
    tx_words.delete();
    cs = 32'd0;
    for (int i = 0; i < int'(MAXW); i++) begin
      tx_words.push_back($urandom);
      cs ^= tx_words[i];
    end
    run_load(MAXW, cs, 0, 1'b0);

    // Random loads
    for (int t = 0; t < 25; t++) begin
      tx_words.delete();
      n  = $urandom_range(0, 6);
      cs = 32'd0;
      for (int i = 0; i < n; i++) begin
        tx_words.push_back($urandom);
        cs ^= tx_words[i];
      end
      len = 32'(n);
      if ($urandom_range(0, 5) == 0) len = MAXW + 1 + $urandom_range(0, 100000);
      if ($urandom_range(0, 3) == 0) cs ^= (32'd1 << $urandom_range(0, 31));
      run_load(len, cs, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
